// File: rtl/core_lock_pkg.sv
// Shared types and constants for the two-core lock arbiter.
package core_lock_pkg;

  localparam int STATE_W = 2;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/core_lock_arbiter_hold_timer.sv
// Hold watchdog: counts cycles of ownership and flags when the limit is hit.
module hold_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (en)  r_cnt <= r_cnt + 1'b1;
  end

  // Fires on the cycle whose increment would reach TIMEOUT, so the revoke
  // edge lands exactly TIMEOUT cycles after the grant edge.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign expired   = en && !clr && (w_cnt_inc == (CNT_W+1)'(TIMEOUT));

endmodule

// File: rtl/core_lock_arbiter.sv
// Two-core lock arbiter with round-robin tie break and zero-bubble handoff.
// Optional hold watchdog enabled by defining CORE_LOCK_TIMEOUT_EN.
module core_lock_arbiter
  import core_lock_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] rel,
  output logic [1:0] stall,
  output logic [1:0] grant,
  output logic       owner,
  output logic       busy,
  output logic       timeout_flag
);

  if (TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
    $error("TIMEOUT must be below 2**CNT_W");
  end

  state_t     r_state;
  state_t     w_state_next;
  logic       r_prio;
  logic       w_prio_next;
  logic       w_grant_evt;
  logic       w_timeout;
  logic       w_expired;
  logic [1:0] w_grant_next;
  logic       w_owner_next;

  logic [1:0] r_stall;
  logic [1:0] r_grant;
  logic       r_owner;
  logic       r_busy;
  logic       r_timeout_flag;

`ifdef CORE_LOCK_TIMEOUT_EN
  hold_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_grant_evt),
    .en      (r_state != IDLE),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_prio_next  = r_prio;
    w_grant_evt  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req[0] && (!req[1] || r_prio == CORE0)) begin
          w_state_next = OWN0;
          w_prio_next  = CORE1;
          w_grant_evt  = 1'b1;
        end else if (req[1]) begin
          w_state_next = OWN1;
          w_prio_next  = CORE0;
          w_grant_evt  = 1'b1;
        end
      end
      OWN0: begin
        // Dropping req counts as a release; rel wins over a held req.
        if (rel[0] || !req[0] || w_expired) begin
          w_timeout = w_expired && !rel[0] && req[0];
          if (req[1]) begin
            w_state_next = OWN1;
            w_prio_next  = CORE0;
            w_grant_evt  = 1'b1;
          end else begin
            w_state_next = IDLE;
            if (w_expired) w_prio_next = CORE1;
          end
        end
      end
      OWN1: begin
        if (rel[1] || !req[1] || w_expired) begin
          w_timeout = w_expired && !rel[1] && req[1];
          if (req[0]) begin
            w_state_next = OWN0;
            w_prio_next  = CORE1;
            w_grant_evt  = 1'b1;
          end else begin
            w_state_next = IDLE;
            if (w_expired) w_prio_next = CORE0;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_grant_next = {w_state_next == OWN1, w_state_next == OWN0};
    w_owner_next = r_owner;
    if (w_state_next == OWN0) w_owner_next = CORE0;
    if (w_state_next == OWN1) w_owner_next = CORE1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_prio         <= CORE0;
      r_stall        <= 2'b00;
      r_grant        <= 2'b00;
      r_owner        <= CORE0;
      r_busy         <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_prio         <= w_prio_next;
      r_stall        <= req & ~w_grant_next;
      r_grant        <= w_grant_next;
      r_owner        <= w_owner_next;
      r_busy         <= (w_state_next != IDLE);
      r_timeout_flag <= w_timeout;
    end
  end

  assign stall        = r_stall;
  assign grant        = r_grant;
  assign owner        = r_owner;
  assign busy         = r_busy;
  assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_core_lock_arbiter.sv
// Directed bench for core_lock_arbiter; watchdog checks follow CORE_LOCK_TIMEOUT_EN.
module tb_core_lock_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] rel;
  logic [1:0] stall;
  logic [1:0] grant;
  logic       owner;
  logic       busy;
  logic       timeout_flag;

  int checks   = 0;
  int failures = 0;

  core_lock_arbiter #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .rel          (rel),
    .stall        (stall),
    .grant        (grant),
    .owner        (owner),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_grant, input logic [1:0] e_stall,
                         input logic e_owner, input logic e_busy, input logic e_tf);
    chk({tag, ".grant"}, {6'd0, grant}, {6'd0, e_grant});
    chk({tag, ".stall"}, {6'd0, stall}, {6'd0, e_stall});
    chk({tag, ".owner"}, {7'd0, owner}, {7'd0, e_owner});
    chk({tag, ".busy"},  {7'd0, busy},  {7'd0, e_busy});
    chk({tag, ".tflag"}, {7'd0, timeout_flag}, {7'd0, e_tf});
  endtask

  initial begin
    rst = 1'b0;
    req = 2'b00;
    rel = 2'b00;
    step();
    step();
    chk_all("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // single requester
    req = 2'b01;
    step();
    chk_all("single_req", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);

    // release from non-owner ignored
    rel = 2'b10;
    step();
    rel = 2'b00;
    chk_all("nonowner_rel", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);

    // owner drops req without rel
    req = 2'b00;
    step();
    chk_all("req_drop", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // rel in IDLE ignored
    rel = 2'b01;
    step();
    rel = 2'b00;
    chk_all("idle_rel", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // reset again so prio is back to core 0
    rst = 1'b0;
    #1;
    chk_all("reset2", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b1;

    // contention: core 0 wins first
    req = 2'b11;
    step();
    chk_all("contend", 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);

    // zero-bubble handoff, core 0 drops its request with the release
    req = 2'b10;
    rel = 2'b01;
    step();
    rel = 2'b00;
    chk_all("handoff", 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);

    // alternation with req=11 held
    req = 2'b11;
    step();
    chk_all("alt_hold1", 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
    rel = 2'b10;
    step();
    chk_all("alt_01", 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);
    rel = 2'b01;
    step();
    chk_all("alt_10", 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
    rel = 2'b10;
    step();
    rel = 2'b00;
    chk_all("alt_01b", 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);

    // rel and req together with no other requester: release wins for a cycle
    req = 2'b01;
    rel = 2'b01;
    step();
    rel = 2'b00;
    chk_all("rel_wins", 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("rearb", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);

    // core 0 holds while core 1 waits
    req = 2'b11;
`ifdef CORE_LOCK_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_all("wd_hold", 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);
    end
    step();
    chk_all("wd_revoke", 2'b10, 2'b01, 1'b1, 1'b1, 1'b1);
`else
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_all("unbounded", 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);
    end
    rel = 2'b01;
    step();
    rel = 2'b00;
    chk_all("to_core1", 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
`endif

    // asynchronous reset mid-ownership of core 1
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("rst_held", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_all("post_rst", 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
